dvp_pattern_gen: RTL
====================

Name: dvp_pattern_gen

Overview:
- Synthesizable, parametrised DVP video source for the ISP-lite pipeline, used on-chip as a sensor stand-in and in benches as a known-good stimulus.
- Generates the same front/pulse/back/display raster as the sensor model: hsync, vsync, href and pixel data.
- Pixels are CHANNELS lanes of BITS each.
- Selectable test patterns, frame-count limit, and clean start/stop on frame boundaries.

Parameters:
BITS, 8, bits per channel (1..16)
CHANNELS, 1, channels per pixel (1..4); data width = BITS*CHANNELS
H_FRONT, 50, pixels before hsync pulse
H_PULSE, 100, hsync pulse width in pixels
H_BACK, 50, pixels after hsync pulse
H_DISP, 1280, active pixels per line (multiple of 8)
V_FRONT, 10, lines before vsync pulse
V_PULSE, 20, vsync pulse width in lines
V_BACK, 10, lines after vsync pulse
V_DISP, 960, active lines
H_POL, 0, hsync active level
V_POL, 1, vsync active level

Ports:
pclk  in  1  pixel clock
rst  in  1  synchronous active-high reset
enable  in  1  run request; start and stop happen on frame boundaries
mode  in  3  pattern select, sampled at frame start
solid  in  BITS*CHANNELS  solid-colour value, sampled at frame start
frame_limit  in  16  frames to emit per run; 0 = unlimited
href  out  1  active-pixel qualifier
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
data  out  BITS*CHANNELS  pixel data; lane c = data[c*BITS +: BITS]
frame_start  out  1  one-cycle pulse on the first cycle of each frame
frame_cnt  out  16  frames completed in the current run
busy  out  1  high while in RUN

Behaviour:
- Reset is one clock, pclk only, synchronous and active-high.
- Reset values: href=0, hsync=~H_POL, vsync=~V_POL, data=0, frame_start=0, frame_cnt=0, busy=0, state=IDLE, counters=0. Reset mid-frame aborts the frame at the next edge.
- Timing constants: H_TOTAL = sum of the H_* parameters. V_TOTAL = sum of the V_* parameters. HA = H_FRONT+H_PULSE+H_BACK. VA = V_FRONT+V_PULSE+V_BACK.
- FSM has two states, IDLE and RUN.
- IDLE:
  - pix_cnt and line_cnt are held at 0; outputs sit at their reset values.
  - enable=1 -> RUN at the next edge, and frame_cnt clears to 0 on the same edge.
- RUN:
  - pix_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - line_cnt increments when pix_cnt = H_TOTAL-1 and wraps from V_TOTAL-1 to 0.
- End of frame is the cycle where pix_cnt = H_TOTAL-1 and line_cnt = V_TOTAL-1. On that cycle:
  - frame_cnt increments, wrapping at 16 bits.
  - If enable=0, or frame_limit!=0 and frame_cnt+1 = frame_limit: go to IDLE.
  - Otherwise the next frame starts immediately, with no gap.
- enable dropping mid-frame has no effect until end of frame; the current frame always completes.
- Config latch: mode and solid are registered while (RUN, pix_cnt=0, line_cnt=0). The latched values apply to the whole frame, so mid-frame changes are ignored.
- Output registration: all outputs are registered functions of (state, pix_cnt, line_cnt), giving 1-cycle latency from the counters:
  - hsync = H_POL when H_FRONT <= pix_cnt < H_FRONT+H_PULSE, else ~H_POL.
  - vsync = V_POL when V_FRONT <= line_cnt < V_FRONT+V_PULSE, else ~V_POL.
  - href = 1 when pix_cnt >= HA and line_cnt >= VA.
  - frame_start = 1 when pix_cnt=0 and line_cnt=0.
  - data = 0 whenever href=0.
- Active coordinates: x = pix_cnt-HA, y = line_cnt-VA. Lane c value for each latched mode:
  - 0, solid: lane c of the latched solid value.
  - 1, horizontal ramp: (x + c) mod 2^BITS.
  - 2, vertical ramp: (y + c) mod 2^BITS.
  - 3, checker: all-ones if x[4]^y[4], else 0. Coordinates are at least 5 bits wide.
  - 4, colour bars: bar index b = x/(H_DISP/8). Lane c is all-ones if bit (c mod 3) of (7-b) is 1, else 0. Bar 0 is white and bar 7 is black.
  - 5, frame counter: lane c = frame_cnt latched at frame start, truncated or zero-extended to BITS.
  - 6 and 7: reserved, output 0.
- busy is registered: 1 from the cycle after IDLE->RUN until the cycle after RUN->IDLE.
- enable held high together with frame_limit reached: the block stops after the last frame and restarts from IDLE on the next edge with frame_cnt cleared. The resulting 1-cycle IDLE gap is permitted.

Test Plan:
All scenarios use BITS=8, CHANNELS=3, H 2/3/2/16, V 1/2/1/4 (H_TOTAL=23, V_TOTAL=8, 184 cycles/frame).
1. Reset, enable=1, mode=1, frame_limit=0.
   - Required: 64 href-high cycles per frame, in 4 bursts of 16.
   - First pixel data = {8'h02,8'h01,8'h00}; last pixel of each line = {8'h11,8'h10,8'h0F}.
   - hsync low for 3 cycles each line; vsync high for 46 cycles.
2. mode=4, one frame.
   - Required: each bar spans 2 pixels.
   - Pixels x=0..1 = 24'hFFFFFF, x=2..3 = 24'hFFFF00 (lane 0 = 0, lanes 1 and 2 all-ones), x=14..15 = 24'h000000.
3. frame_limit=3, mode=5, enable held high.
   - Lane data = 0, 1, 2 in frames 1 to 3.
   - frame_cnt = 3 when busy falls 553 cycles after start (3×184 + 1).
   - Then a 1-cycle IDLE gap and a restart with frame_cnt=0.
4. Toggle mode 1->3 mid-frame, then drop enable mid-frame.
   - Required: the current frame stays ramp and completes all 64 href cycles.
   - No further frame_start; busy=0 afterwards.
5. Assert rst during an active line.
   - Required: the next cycle shows href=0, hsync=1, vsync=0, data=0, frame_cnt=0, busy=0.
6. CHANNELS=1, mode=0, solid=8'hA5.
   - Required: every href cycle data = 8'hA5, and data=0 outside href.

Source files
------------

// File: rtl/dvp_pattern_gen.sv
`timescale 1ns/1ps
// dvp_pattern_gen: parametrised DVP raster and test-pattern source.
// Runs start and stop only on frame boundaries; every output is registered one cycle after the counters.
module dvp_pattern_gen #(
    parameter int unsigned BITS     = 8,
    parameter int unsigned CHANNELS = 1,
    parameter int unsigned H_FRONT  = 50,
    parameter int unsigned H_PULSE  = 100,
    parameter int unsigned H_BACK   = 50,
    parameter int unsigned H_DISP   = 1280,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned V_PULSE  = 20,
    parameter int unsigned V_BACK   = 10,
    parameter int unsigned V_DISP   = 960,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b1
) (
    input  logic                     i_pclk,
    input  logic                     i_rst,
    input  logic                     i_enable,
    input  logic [2:0]               i_mode,
    input  logic [BITS*CHANNELS-1:0] i_solid,
    input  logic [15:0]              i_frame_limit,
    output logic                     o_href,
    output logic                     o_hsync,
    output logic                     o_vsync,
    output logic [BITS*CHANNELS-1:0] o_data,
    output logic                     o_frame_start,
    output logic [15:0]              o_frame_cnt,
    output logic                     o_busy
);
    localparam int unsigned DW      = BITS * CHANNELS;
    localparam int unsigned HA      = H_FRONT + H_PULSE + H_BACK;
    localparam int unsigned VA      = V_FRONT + V_PULSE + V_BACK;
    localparam int unsigned H_TOTAL = HA + H_DISP;
    localparam int unsigned V_TOTAL = VA + V_DISP;
    localparam int unsigned BAR_W   = H_DISP / 8;

    typedef enum logic {StIdle, StRun} state_t;

    state_t          r_state, w_state_d;
    logic [15:0]     r_pix_cnt, r_line_cnt, r_frame_cnt, r_fc_lat;
    logic [15:0]     w_pix_d, w_line_d, w_frame_cnt_d, w_frame_inc;
    logic [2:0]      r_mode;
    logic [DW-1:0]   r_solid;
    logic            r_href, r_hsync, r_vsync, r_frame_start, r_busy;
    logic [DW-1:0]   r_data;

    logic            w_run, w_line_end, w_frame_end, w_frame_first, w_stop;
    logic [2:0]      w_mode;
    logic [DW-1:0]   w_solid;
    logic [15:0]     w_fc_lat, w_x, w_y;
    logic [2:0]      w_bar;
    logic            w_href, w_hsync, w_vsync;
    logic [DW-1:0]   w_data;

    assign w_run         = (r_state == StRun);
    assign w_line_end    = (r_pix_cnt == 16'(H_TOTAL - 1));
    assign w_frame_end   = w_run && w_line_end && (r_line_cnt == 16'(V_TOTAL - 1));
    assign w_frame_first = w_run && (r_pix_cnt == 16'd0) && (r_line_cnt == 16'd0);
    assign w_frame_inc   = r_frame_cnt + 16'd1;
    assign w_stop        = !i_enable || ((i_frame_limit != 16'd0) && (w_frame_inc == i_frame_limit));

    always_comb begin
        w_state_d     = r_state;
        w_pix_d       = '0;
        w_line_d      = '0;
        w_frame_cnt_d = r_frame_cnt;
        case (r_state)
            StIdle: begin
                if (i_enable) begin
                    w_state_d     = StRun;
                    w_frame_cnt_d = '0;
                end
            end
            StRun: begin
                w_pix_d  = w_line_end ? 16'd0 : r_pix_cnt + 16'd1;
                w_line_d = r_line_cnt;
                if (w_line_end) begin
                    w_line_d = (r_line_cnt == 16'(V_TOTAL - 1)) ? 16'd0 : r_line_cnt + 16'd1;
                end
                if (w_frame_end) begin
                    w_frame_cnt_d = w_frame_inc;
                    if (w_stop) w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Config is captured on the frame's first counter cycle; forward it so that cycle already sees it.
    assign w_mode   = w_frame_first ? i_mode      : r_mode;
    assign w_solid  = w_frame_first ? i_solid     : r_solid;
    assign w_fc_lat = w_frame_first ? r_frame_cnt : r_fc_lat;

    assign w_x     = r_pix_cnt - 16'(HA);
    assign w_y     = r_line_cnt - 16'(VA);
    assign w_bar   = 3'(16'd7 - (w_x / 16'(BAR_W)));
    assign w_href  = w_run && (r_pix_cnt >= 16'(HA)) && (r_line_cnt >= 16'(VA));
    assign w_hsync = (w_run && (r_pix_cnt >= 16'(H_FRONT)) && (r_pix_cnt < 16'(H_FRONT + H_PULSE)))
                     ? H_POL : ~H_POL;
    assign w_vsync = (w_run && (r_line_cnt >= 16'(V_FRONT)) &&
                      (r_line_cnt < 16'(V_FRONT + V_PULSE))) ? V_POL : ~V_POL;

    always_comb begin
        w_data = '0;
        if (w_href) begin
            for (int c = 0; c < CHANNELS; c++) begin
                case (w_mode)
                    3'd0: w_data[c*BITS +: BITS] = w_solid[c*BITS +: BITS];
                    3'd1: w_data[c*BITS +: BITS] = BITS'(w_x + 16'(c));
                    3'd2: w_data[c*BITS +: BITS] = BITS'(w_y + 16'(c));
                    3'd3: w_data[c*BITS +: BITS] = (w_x[4] ^ w_y[4]) ? {BITS{1'b1}} : {BITS{1'b0}};
                    3'd4: w_data[c*BITS +: BITS] = w_bar[2'(c % 3)] ? {BITS{1'b1}} : {BITS{1'b0}};
                    3'd5: w_data[c*BITS +: BITS] = BITS'(w_fc_lat);
                    default: w_data[c*BITS +: BITS] = '0;
                endcase
            end
        end
    end

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_pix_cnt     <= '0;
            r_line_cnt    <= '0;
            r_frame_cnt   <= '0;
            r_fc_lat      <= '0;
            r_mode        <= '0;
            r_solid       <= '0;
            r_href        <= 1'b0;
            r_hsync       <= ~H_POL;
            r_vsync       <= ~V_POL;
            r_data        <= '0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_pix_cnt     <= w_pix_d;
            r_line_cnt    <= w_line_d;
            r_frame_cnt   <= w_frame_cnt_d;
            r_fc_lat      <= w_fc_lat;
            r_mode        <= w_mode;
            r_solid       <= w_solid;
            r_href        <= w_href;
            r_hsync       <= w_hsync;
            r_vsync       <= w_vsync;
            r_data        <= w_data;
            r_frame_start <= w_frame_first;
            r_busy        <= w_run;
        end
    end

    assign o_href        = r_href;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_data        = r_data;
    assign o_frame_start = r_frame_start;
    assign o_frame_cnt   = r_frame_cnt;
    assign o_busy        = r_busy;
endmodule
